// File: rtl/i2c_slave_regbus.sv
// i2c_slave_regbus: I2C/SCCB responder that turns 16-bit-address register transactions
// into single-cycle register-bus write/read strobes.
module i2c_slave_regbus #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3c
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);
  localparam logic [3:0] IDLE = 4'd0, DEV = 4'd1, ACK_DEV = 4'd2, AH = 4'd3, ACK_AH = 4'd4,
    AL = 4'd5, ACK_AL = 4'd6, WDATA = 4'd7, ACK_WD = 4'd8, RDATA = 4'd9, MACK = 4'd10;
  logic [2:0]  r_scl_q, r_sda_q;
  logic [3:0]  r_state;
  logic [2:0]  r_cnt;
  logic [6:0]  r_sh;
  logic [7:0]  r_ah, r_wdata;
  logic [15:0] r_addr;
  logic        r_rw, r_sda_oe, r_wr_en, r_rd_en, r_busy;
  logic        w_rise, w_fall, w_start, w_stop, w_sda, w_last, w_shift, w_ack;
  logic [7:0]  w_byte;
  logic [3:0]  w_ack_next;
  always_comb begin
    w_rise     = r_scl_q[1] & ~r_scl_q[2];
    w_fall     = ~r_scl_q[1] & r_scl_q[2];
    w_start    = r_scl_q[1] & r_scl_q[2] & ~r_sda_q[1] & r_sda_q[2];
    w_stop     = r_scl_q[1] & r_scl_q[2] & r_sda_q[1] & ~r_sda_q[2];
    w_sda      = r_sda_q[1];
    w_byte     = {r_sh, w_sda};
    w_last     = r_cnt == 3'd7;
    w_shift    = r_state == DEV || r_state == AH || r_state == AL || r_state == WDATA;
    w_ack      = r_state == ACK_DEV || r_state == ACK_AH || r_state == ACK_AL || r_state == ACK_WD;
    w_ack_next = r_state == ACK_DEV ? (r_rw ? RDATA : AH) : r_state == ACK_AH ? AL : WDATA;
  end
  // r_cnt is a 3-bit bit counter that wraps to 0 after the eighth bit; inside ACK and MACK
  // states it marks whether the ninth clock has been passed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_q  <= 3'b111;
      r_sda_q  <= 3'b111;
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_sh     <= 7'd0;
      r_ah     <= 8'd0;
      r_wdata  <= 8'd0;
      r_addr   <= 16'd0;
      r_rw     <= 1'b0;
      r_sda_oe <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_scl_q <= {r_scl_q[1:0], scl};
      r_sda_q <= {r_sda_q[1:0], sda_in};
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= DEV;
        r_cnt    <= 3'd0;
        r_sda_oe <= 1'b0;
      end else if (r_state == RDATA && r_rd_en) begin
        r_sh     <= reg_rdata[6:0];
        r_sda_oe <= ~reg_rdata[7];
        r_cnt    <= 3'd0;
      end else if (w_rise && w_shift) begin
        r_sh  <= w_byte[6:0];
        r_cnt <= r_cnt + 3'd1;
        if (w_last)
          case (r_state)
            DEV: begin
              r_state <= w_byte[7:1] == SLAVE_ADDR ? ACK_DEV : IDLE;
              r_busy  <= w_byte[7:1] == SLAVE_ADDR;
              r_rw    <= w_byte[0];
            end
            AH: begin
              r_ah    <= w_byte;
              r_state <= ACK_AH;
            end
            AL: begin
              r_addr  <= {r_ah, w_byte};
              r_state <= ACK_AL;
            end
            default: begin
              r_wdata <= w_byte;
              r_wr_en <= 1'b1;
              r_state <= ACK_WD;
            end
          endcase
      end else if (w_rise && r_state == MACK) begin
        if (w_sda) r_state <= IDLE;
        else begin
          r_addr <= r_addr + 16'd1;
          r_cnt  <= 3'd1;
        end
      end else if (w_fall && w_ack) begin
        if (r_cnt == 3'd0) begin
          r_sda_oe <= 1'b1;
          r_cnt    <= 3'd1;
        end else begin
          r_sda_oe <= 1'b0;
          r_cnt    <= 3'd0;
          r_state  <= w_ack_next;
          r_rd_en  <= r_state == ACK_DEV && r_rw;
          if (r_state == ACK_WD) r_addr <= r_addr + 16'd1;
        end
      end else if (w_fall && r_state == RDATA) begin
        r_cnt    <= r_cnt + 3'd1;
        r_sh     <= {r_sh[5:0], 1'b0};
        r_sda_oe <= ~w_last & ~r_sh[6];
        if (w_last) r_state <= MACK;
      end else if (w_fall && r_state == MACK && r_cnt == 3'd1) begin
        r_rd_en <= 1'b1;
        r_cnt   <= 3'd0;
        r_state <= RDATA;
      end
    end
  end
  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr_en = r_wr_en;
  assign reg_rd_en = r_rd_en;
  assign busy      = r_busy;
endmodule

// File: tb/tb_i2c_slave_regbus.sv
// tb_i2c_slave_regbus: bit-banged I2C master, register-file responder and a transaction-level
// reference model for i2c_slave_regbus.
module tb_i2c_slave_regbus;
  localparam int H = 6;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_pull = 1'b0;
  logic sda_in, sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata = 8'h00;
  assign sda_in = ~(sda_oe | m_pull);
  always #5 clk = ~clk;

  i2c_slave_regbus dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {
    logic [7:0] dev; logic [2:0] n; logic [31:0] b; logic [4:0] acks;
    logic [1:0] nwr; logic [15:0] wa0; logic [15:0] addr; logic [7:0] wdata;
  } vec_t;

  wr_t wr_log[$], exp_wr[$];
  logic [15:0] rd_log[$], exp_rd[$];
  logic [7:0] exp_d[$];
  logic [15:0] m_ptr = 16'h0000;
  int total = 0, bad = 0, both_cnt = 0, hi_chg = 0;
  logic prev_oe = 1'b0;

  function automatic logic [7:0] rom(logic [15:0] a);
    return a == 16'h300a ? 8'h56 : a[15:8] ^ a[7:0] ^ 8'ha5;
  endfunction

  // Register file: answers a read request with data one clk later; also logs strobes.
  always @(negedge clk) begin
    if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_rd_en) begin
      rd_log.push_back(reg_addr);
      reg_rdata = rom(reg_addr);
    end
    if (reg_wr_en && reg_rd_en) both_cnt++;
    if (rst_n && scl && sda_oe != prev_oe) hi_chg++;
    prev_oe = sda_oe;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: no finish by 1ms, want finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_pull = ~b; tick(H); scl = 1'b1; tick(H); s = sda_in; tick(H); scl = 1'b0; tick(H);
  endtask

  task automatic i2c_start;
    m_pull = 1'b0; tick(H); scl = 1'b1; tick(H); m_pull = 1'b1; tick(H); scl = 1'b0; tick(H);
  endtask

  task automatic i2c_stop;
    m_pull = 1'b1; tick(H); scl = 1'b1; tick(H); m_pull = 1'b0; tick(2 * H);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~mack, s);
  endtask

  task automatic wr_tx(input logic [7:0] dev, input logic [7:0] b[$], input bit stop,
                       output logic [4:0] acks);
    logic a;
    wr_log.delete(); rd_log.delete();
    acks = 5'd0;
    i2c_start;
    send_byte(dev, a);
    acks[0] = a;
    foreach (b[i]) begin
      send_byte(b[i], a);
      acks[i + 1] = a;
    end
    if (stop) i2c_stop;
  endtask

  task automatic rd_tx(input int n, output logic a, output logic [7:0] d[$]);
    logic [7:0] x;
    d = {};
    i2c_start;
    send_byte(8'h79, a);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, x);
      d.push_back(x);
    end
    i2c_stop;
  endtask

  // Reference model: pointer bytes, then data bytes stored at an auto-incrementing pointer.
  function automatic logic [4:0] model_wr(logic [7:0] dev, logic [7:0] b[$]);
    logic [7:0] hi = 8'h00;
    if (dev != 8'h78) return 5'd0;
    foreach (b[i]) begin
      if (i == 0) hi = b[i];
      else if (i == 1) m_ptr = {hi, b[i]};
      else begin
        exp_wr.push_back({m_ptr, b[i]});
        m_ptr = m_ptr + 16'd1;
      end
    end
    return 5'((1 << (b.size() + 1)) - 1);
  endfunction

  function automatic void model_rd(int n);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(m_ptr);
      exp_d.push_back(rom(m_ptr));
      if (i < n - 1) m_ptr = m_ptr + 16'd1;
    end
  endfunction

  task automatic cmp_logs(string tag);
    chk({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    foreach (exp_wr[i]) if (i < wr_log.size()) chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
    chk({tag, "_nrd"}, rd_log.size(), exp_rd.size());
    foreach (exp_rd[i]) if (i < rd_log.size()) chk({tag, "_rd"}, rd_log[i], exp_rd[i]);
  endtask

  initial begin
    vec_t vt[6];
    logic [7:0] q[$], d[$];
    logic [7:0] dev;
    logic [4:0] acks, eacks;
    logic a, s;
    int r, nd, nr;

    vt[0] = '{8'h78, 3'd3, 32'h30088200, 5'b01111, 2'd1, 16'h3008, 16'h3009, 8'h82};
    vt[1] = '{8'h7a, 3'd3, 32'h30089900, 5'b00000, 2'd0, 16'h0000, 16'h3009, 8'h82};
    vt[2] = '{8'h78, 3'd4, 32'hffff1122, 5'b11111, 2'd2, 16'hffff, 16'h0001, 8'h22};
    vt[3] = '{8'h78, 3'd1, 32'h12000000, 5'b00011, 2'd0, 16'h0000, 16'h0001, 8'h22};
    vt[4] = '{8'h78, 3'd2, 32'h43000000, 5'b00111, 2'd0, 16'h0000, 16'h4300, 8'h22};
    vt[5] = '{8'h78, 3'd3, 32'habcd5a00, 5'b01111, 2'd1, 16'habcd, 16'habce, 8'h5a};

    tick(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_addr", reg_addr, 16'h0000);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_wr", reg_wr_en, 0);
    chk("rst_rd", reg_rd_en, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    for (int k = 0; k < 6; k++) begin
      q = {};
      for (int i = 0; i < int'(vt[k].n); i++) q.push_back(vt[k].b[31 - 8 * i -: 8]);
      void'(model_wr(vt[k].dev, q));
      wr_tx(vt[k].dev, q, 1'b1, acks);
      chk($sformatf("v%0d_acks", k), acks, vt[k].acks);
      chk($sformatf("v%0d_nwr", k), wr_log.size(), vt[k].nwr);
      chk($sformatf("v%0d_nrd", k), rd_log.size(), 0);
      chk($sformatf("v%0d_addr", k), reg_addr, vt[k].addr);
      chk($sformatf("v%0d_wdata", k), reg_wdata, vt[k].wdata);
      chk($sformatf("v%0d_busy", k), busy, 0);
      if (vt[k].nwr != 0 && wr_log.size() != 0) begin
        chk($sformatf("v%0d_wa0", k), wr_log[0].a, vt[k].wa0);
        chk($sformatf("v%0d_wa_last", k), wr_log[$].a, vt[k].addr - 16'd1);
        chk($sformatf("v%0d_wd_last", k), wr_log[$].d, vt[k].wdata);
      end
    end

    // Random read of 0x300A through a repeated START.
    exp_wr.delete(); exp_rd.delete(); exp_d.delete();
    q = {8'h30, 8'h0a};
    void'(model_wr(8'h78, q));
    wr_tx(8'h78, q, 1'b0, acks);
    chk("rr_ptr_acks", acks, 5'b00111);
    chk("rr_busy_mid", busy, 1);
    rd_tx(1, a, d);
    chk("rr_dev_ack", a, 1);
    chk("rr_data", d[0], 8'h56);
    chk("rr_nrd", rd_log.size(), 1);
    if (rd_log.size() != 0) chk("rr_rd_addr", rd_log[0], 16'h300a);
    chk("rr_oe", sda_oe, 0);
    chk("rr_busy", busy, 0);
    model_rd(1);

    // Burst read of three bytes from 0x4300.
    exp_wr.delete(); exp_rd.delete(); exp_d.delete();
    q = {8'h43, 8'h00};
    void'(model_wr(8'h78, q));
    wr_tx(8'h78, q, 1'b0, acks);
    rd_tx(3, a, d);
    model_rd(3);
    cmp_logs("br");
    chk("br_nd", d.size(), 3);
    foreach (exp_d[i]) if (i < d.size()) chk("br_data", d[i], exp_d[i]);
    chk("br_addr", reg_addr, 16'h4302);

    // STOP after four bits of a data byte.
    exp_wr.delete(); exp_rd.delete(); exp_d.delete();
    q = {8'h30, 8'h08};
    void'(model_wr(8'h78, q));
    wr_tx(8'h78, q, 1'b0, acks);
    for (int i = 0; i < 4; i++) bit_io(i[0], s);
    i2c_stop;
    chk("ab_nwr", wr_log.size(), 0);
    chk("ab_busy", busy, 0);
    chk("ab_addr", reg_addr, 16'h3008);
    q = {8'h30, 8'h08, 8'h77};
    void'(model_wr(8'h78, q));
    wr_tx(8'h78, q, 1'b1, acks);
    chk("ab_next_acks", acks, 5'b01111);
    cmp_logs("ab_next");

    for (int t = 0; t < 10; t++) begin
      exp_wr.delete(); exp_rd.delete(); exp_d.delete();
      q = {};
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 126);
        if (r >= 60) r++;
        dev = {r[6:0], 1'b0};
      end else dev = 8'h78;
      q.push_back($urandom_range(0, 2) == 0 ? 8'hff : 8'($urandom));
      q.push_back($urandom_range(0, 2) == 0 ? 8'hff : 8'($urandom));
      nd = $urandom_range(0, 2);
      for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
      nr = (dev == 8'h78 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      eacks = model_wr(dev, q);
      wr_tx(dev, q, nr == 0, acks);
      chk($sformatf("rnd%0d_acks", t), acks, eacks);
      if (nr != 0) begin
        rd_tx(nr, a, d);
        model_rd(nr);
        chk($sformatf("rnd%0d_rack", t), a, 1);
        chk($sformatf("rnd%0d_nd", t), d.size(), nr);
        foreach (exp_d[i]) if (i < d.size()) chk($sformatf("rnd%0d_data", t), d[i], exp_d[i]);
      end
      cmp_logs($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_addr", t), reg_addr, m_ptr);
      chk($sformatf("rnd%0d_busy", t), busy, 0);
    end

    // Reset while the block holds the device-address ACK.
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_io(i == 6 || i == 5 || i == 4 || i == 3, s);
    m_pull = 1'b0;
    for (int i = 0; i < 40 && !sda_oe; i++) tick(1);
    chk("rs_ack_drv", sda_oe, 1);
    scl = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rs_oe_async", sda_oe, 0);
    tick(2);
    chk("rs_addr", reg_addr, 16'h0000);
    chk("rs_wdata", reg_wdata, 8'h00);
    chk("rs_busy", busy, 0);
    chk("rs_wr", reg_wr_en, 0);
    chk("rs_rd", reg_rd_en, 0);
    rst_n = 1'b1;
    m_ptr = 16'h0000;
    tick(5);
    exp_wr.delete(); exp_rd.delete(); exp_d.delete();
    q = {8'h12, 8'h34, 8'h56};
    eacks = model_wr(8'h78, q);
    wr_tx(8'h78, q, 1'b1, acks);
    chk("rs_next_acks", acks, eacks);
    cmp_logs("rs_next");

    chk("no_overlap", both_cnt, 0);
    chk("oe_steady_scl_hi", hi_chg, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regbus.md
# i2c_slave_regbus

I2C/SCCB responder that decodes the 16-bit-register-address camera-configuration protocol and converts each transaction into single-cycle register-bus strobes. It is the target-side counterpart of the sensor configuration master. It lets an FPGA-hosted register file, such as a sensor model for simulation or a board-level shadow register bank, answer write and read sequences exactly as an OV5640 does. It sits between the open-drain SCL/SDA pads and a simple synchronous register bus.

## Interface
- SLAVE_ADDR, 7'h3c, 7-bit device address that the block acknowledges
- clk  input  1  system clock (50 MHz nominal); all logic synchronous to it
- rst_n  input  1  asynchronous, active-low reset
- scl  input  1  I2C clock from pad (asynchronous to clk)
- sda_in  input  1  I2C data sampled from pad (asynchronous to clk)
- sda_oe  output  1  1 = pull SDA low; 0 = release (pad is open-drain)
- reg_addr  output  16  current register pointer
- reg_wdata  output  8  write data; valid while reg_wr_en=1
- reg_wr_en  output  1  one-clk write strobe
- reg_rd_en  output  1  one-clk read request
- reg_rdata  input  8  read data; must be valid exactly 1 clk after reg_rd_en
- busy  output  1  high from a valid START until STOP or abort

## Operation
- Input conditioning: scl and sda_in each pass through a 2-flop synchronizer plus a history flop. Edges are derived from the synchronized values. START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- START or repeated START from any state clears the bit counter and goes to DEV. STOP from any state goes to IDLE, releases sda_oe and clears busy.
- States: IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WDATA, ACK_WD, RDATA, MACK.
- DEV: shift 8 bits MSB-first on SCL rising edges.
  - If bits[7:1] != SLAVE_ADDR, go to IDLE without driving SDA (NACK) and ignore everything until the next START.
  - On a match, go to ACK_DEV with the R/W bit latched and busy set.
- ACK_DEV: drive sda_oe=1 for the 9th clock.
  - If W, next state is AH.
  - If R, next state is RDATA. Pulse reg_rd_en once, at the SCL falling edge that ends the ACK bit. The byte is loaded into the transmit shifter the following clk.
- AH / AL: shift the high / low address byte, then ACK. After ACK_AL, reg_addr = {AH, AL} and the next state is WDATA.
- WDATA: shift 8 bits, then go to ACK_WD.
  - reg_wr_en pulses for 1 clk on the SCL rising edge that samples bit 0, with reg_wdata = the shifted byte at the current reg_addr.
  - ACK is driven, then reg_addr increments at the end of ACK_WD and the state returns to WDATA (burst write).
- RDATA: present the byte MSB-first. sda_oe = ~bit, updated only after SCL falling edges. After 8 bits, release SDA and go to MACK.
- MACK: sample SDA on the 9th SCL rising edge.
  - ACK (0): increment reg_addr, pulse reg_rd_en at the next SCL falling edge, load the byte, and return to RDATA.
  - NACK (1): go to IDLE-wait; SDA stays released until STOP or START.
- Random read = write AH/AL, repeated START, device address with R. The pointer is preserved across repeated START and across STOP.
- reg_addr arithmetic is modulo 2^16: 0xFFFF increments to 0x0000.

## Timing
- Reset values: sda_oe=0, reg_addr=16'h0000, reg_wdata=8'h00, reg_wr_en=0, reg_rd_en=0, busy=0, state IDLE.
- Pad-to-detect latency: 3 clk. SCL high and low phases must each be ≥8 clk; 250 kHz SCL gives 100 clk per phase.
- SDA output changes no earlier than 1 clk after a detected SCL falling edge. It never changes while SCL is high, so the block generates no false START/STOP.
- The ACK drive holds from the falling edge after bit 8 until the falling edge after bit 9.
- reg_wr_en and reg_rd_en are never asserted in the same clk, and neither fires in IDLE.
- A START or STOP that occurs during a byte aborts that byte: no write strobe is issued for a partial byte.
- rst_n asserted mid-transfer releases SDA immediately (asynchronously) and returns to IDLE. The block then waits for a fresh START.

## Test plan
- Write: START, 0x78, 0x30, 0x08, 0x82, STOP -> three ACKs plus a data ACK; one reg_wr_en with reg_addr=0x3008 and reg_wdata=0x82; busy low after STOP.
- Random read: write pointer 0x300A, repeated START, 0x79; model returns 0x56 -> SDA carries 0x56 MSB-first; master NACK; exactly one reg_rd_en at 0x300A; SDA released.
- Wrong address: START, 0x7A -> no ACK (sda_oe stays 0); following bytes ignored; no strobes.
- Burst/wrap: write pointer 0xFFFF, then data 0x11, 0x22 -> writes at 0xFFFF=0x11 and 0x0000=0x22. Burst read of 3 bytes from 0x4300 -> reg_rd_en at 0x4300, 0x4301, 0x4302.
- Abort: STOP after 4 bits of a data byte -> no reg_wr_en; IDLE; next transaction completes normally.
- Reset: assert rst_n low while the block is driving an ACK -> sda_oe=0 within the same clk; all outputs at reset values.
